wb_ram_arbiter: RTL

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

---
 rtl/wb_ram_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter
//   Two-master Wishbone arbiter in front of a single RAM slave port.
//   Master 0 is the core, master 1 is the debug/loader port. Ownership is
//   granted per Wishbone cycle: the owner keeps the slave until it drops
//   cyc. Ties are broken round-robin against the previous owner. A stalled
//   beat that is not acknowledged within TIMEOUT_CYCLES counted cycles is
//   aborted, and the owner then sees err instead of ack.
//
// Ports
//   wb_clk_i, rst_ni          clock, asynchronous active-low reset
//   mX_addr_i/wdata_i/we_i/stb_i/cyc_i   master X request (X = 0, 1)
//   mX_rdata_o/ack_o/err_o    master X response
//   s_addr_o/wdata_o/we_o/stb_o/cyc_o    shared request to the RAM
//   s_rdata_i, s_ack_i        RAM response
//   grant_o                   one-hot current owner, 2'b00 when idle
//
// The slave-side request and master responses are combinational views of
// the registered owner/state, so an asynchronous reset clears every output
// immediately without waiting for a clock edge.
// ---------------------------------------------------------------------------
module wb_ram_arbiter #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_ni,
    input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [31:0]              m0_wdata_i,
    input  logic                     m0_we_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_cyc_i,
    output logic [31:0]              m0_rdata_o,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,
    input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [31:0]              m1_wdata_i,
    input  logic                     m1_we_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_cyc_i,
    output logic [31:0]              m1_rdata_o,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,
    output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
    output logic [31:0]              s_wdata_o,
    output logic                     s_we_o,
    output logic                     s_stb_o,
    output logic                     s_cyc_o,
    input  logic [31:0]              s_rdata_i,
    input  logic                     s_ack_i,
    output logic [1:0]               grant_o
);

    // A zero timeout still needs a one-bit counter to keep the logic legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 32'sd0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             TO_EN     = (TIMEOUT_CYCLES > 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic             owner_r, owner_s;   // 0 = m0, 1 = m1
    logic             last_q, last_s;     // owner of the previous cycle
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic req0_s, req1_s, own_cyc_s, own_stb_s, timeout_hit_s;

    assign req0_s    = m0_cyc_i & m0_stb_i;
    assign req1_s    = m1_cyc_i & m1_stb_i;
    assign own_cyc_s = owner_r ? m1_cyc_i : m0_cyc_i;
    assign own_stb_s = owner_r ? m1_stb_i : m0_stb_i;
    // An ack in the limit cycle takes precedence over the abort.
    assign timeout_hit_s = TO_EN & (cnt_r == CNT_LIMIT) & ~s_ack_i;

    // State, owner, round-robin history and stall counter registers.
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            last_q  <= 1'b1;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_q  <= last_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state: arbitration, cycle hold, timeout and release.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        last_s  = last_q;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                // Clearing here means the counter is zero on entry to BUSY.
                cnt_s = '0;
                if (req0_s || req1_s) begin
                    state_s = ST_BUSY;
                    owner_s = (req0_s && req1_s) ? ~last_q : req1_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!own_cyc_s) begin
                    state_s = ST_IDLE;
                    last_s  = owner_r;
                end else if (s_ack_i) begin
                    cnt_s = '0;
                end else if (timeout_hit_s) begin
                    state_s = ST_ABORT;
                end else if (own_stb_s && (cnt_r != CNT_MAX)) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_ABORT: begin
                if (!own_cyc_s) begin
                    state_s = ST_IDLE;
                    last_s  = owner_r;
                end else begin
                    state_s = ST_ABORT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Output routing: mirror the owner in BUSY, report err in ABORT.
    always_comb begin
        s_addr_o   = '0;
        s_wdata_o  = 32'h0000_0000;
        s_we_o     = 1'b0;
        s_stb_o    = 1'b0;
        s_cyc_o    = 1'b0;
        m0_rdata_o = 32'h0000_0000;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_rdata_o = 32'h0000_0000;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        grant_o    = 2'b00;
        case (state_r)
            ST_BUSY: begin
                grant_o = owner_r ? 2'b10 : 2'b01;
                if (owner_r) begin
                    s_addr_o   = m1_addr_i;
                    s_wdata_o  = m1_wdata_i;
                    s_we_o     = m1_we_i;
                    s_stb_o    = m1_stb_i;
                    s_cyc_o    = m1_cyc_i;
                    m1_rdata_o = s_rdata_i;
                    m1_ack_o   = s_ack_i;
                end else begin
                    s_addr_o   = m0_addr_i;
                    s_wdata_o  = m0_wdata_i;
                    s_we_o     = m0_we_i;
                    s_stb_o    = m0_stb_i;
                    s_cyc_o    = m0_cyc_i;
                    m0_rdata_o = s_rdata_i;
                    m0_ack_o   = s_ack_i;
                end
            end
            ST_ABORT: begin
                // Slave is released; a late s_ack_i is not forwarded.
                grant_o = owner_r ? 2'b10 : 2'b01;
                if (owner_r) begin
                    m1_err_o = m1_stb_i;
                end else begin
                    m0_err_o = m0_stb_i;
                end
            end
            ST_IDLE: begin
                grant_o = 2'b00;
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

endmodule
